// File: rtl/note_seq_pkg.sv
// Shared types and default constants for the note record/playback sequencer.
package note_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_e;

  localparam int NOTE_DEPTH_DEF = 16;
  localparam int NOTE_TICK_DEF  = 25000000;

endpackage

// File: rtl/note_tick_gen.sv
// Playback tempo divider: counts 0..TICK_CYCLES-1 while enabled, held at 0 otherwise.
module note_tick_gen
  import note_seq_pkg::*;
#(
  parameter int TICK_CYCLES = NOTE_TICK_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(TICK_CYCLES);

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == CW'(TICK_CYCLES - 1));

  always_comb begin
    count_d = '0;
    if (enable && !tick) count_d = count_q + CW'(1);
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/note_seq_ctrl.sv
// Record/playback sequencer controller; define NOTE_SEQ_LOOP_EN for looping playback
// with playback-press restart.
module note_seq_ctrl
  import note_seq_pkg::*;
#(
  parameter int DEPTH       = NOTE_DEPTH_DEF,
  parameter int TICK_CYCLES = NOTE_TICK_DEF,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_n,
  input  logic          playback_n,
  input  logic          stop_n,
  input  logic          clear_n,
  output logic          ld_note,
  output logic          ld_play,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   note_count,
  output logic          full,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [3:0]    btn_q, btn_prev_q;
  logic          press_load, press_play, press_stop, press_clear;
  logic          tick, tick_en, last_note;

  // Button order {clear, stop, playback, load}; a press is a registered 1->0 step.
  assign press_load  = btn_prev_q[0] & ~btn_q[0];
  assign press_play  = btn_prev_q[1] & ~btn_q[1];
  assign press_stop  = btn_prev_q[2] & ~btn_q[2];
  assign press_clear = btn_prev_q[3] & ~btn_q[3];

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign last_note = ({1'b0, rd_q} == count_q - (AW+1)'(1));

  assign ld_note    = (state_q == RECORD);
  assign ld_play    = (state_q == PLAY);
  assign busy       = (state_q != IDLE);
  assign wr_addr    = count_q[AW-1:0];
  assign rd_addr    = rd_q;
  assign note_count = count_q;

`ifdef NOTE_SEQ_LOOP_EN
  // Dropping enable for one cycle clears the tempo counter on a restart press.
  assign tick_en = (state_q == PLAY) && !(press_play && !press_stop);
`else
  assign tick_en = (state_q == PLAY);
`endif

  note_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (tick_en),
    .tick   (tick)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_d = state_q;
    count_d = count_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        if (press_clear) begin
          count_d = '0;
        end else if (press_load && !full) begin
          state_d = RECORD;
        end else if (press_play && count_q != '0) begin
          state_d = PLAY;
          rd_d    = '0;
        end
      end
      RECORD: begin
        count_d = count_q + (AW+1)'(1);
        state_d = IDLE;
      end
      PLAY: begin
        if (press_stop) begin
          state_d = IDLE;
          rd_d    = '0;
`ifdef NOTE_SEQ_LOOP_EN
        end else if (press_play) begin
          rd_d = '0;
        end else if (tick) begin
          rd_d = last_note ? '0 : rd_q + AW'(1);
`else
        end else if (tick) begin
          if (last_note) begin
            state_d = IDLE;
            rd_d    = '0;
          end else begin
            rd_d = rd_q + AW'(1);
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rd_q       <= '0;
      btn_q      <= '1;
      btn_prev_q <= '1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      btn_q      <= {clear_n, stop_n, playback_n, load_n};
      btn_prev_q <= btn_q;
    end
  end

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Directed self-checking bench for note_seq_ctrl with DEPTH=4, TICK_CYCLES=4.
module tb_note_seq_ctrl;

  localparam int DEPTH = 4;
  localparam int TICK  = 4;
  localparam int AW    = 2;

  localparam logic [3:0] B_LOAD  = 4'b0001;
  localparam logic [3:0] B_PLAY  = 4'b0010;
  localparam logic [3:0] B_STOP  = 4'b0100;
  localparam logic [3:0] B_CLEAR = 4'b1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_n, playback_n, stop_n, clear_n;
  logic          ld_note, ld_play, full, busy;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW:0]   note_count;

  int checks = 0;
  int errors = 0;

  note_seq_ctrl #(.DEPTH(DEPTH), .TICK_CYCLES(TICK)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_n     (load_n),
    .playback_n (playback_n),
    .stop_n     (stop_n),
    .clear_n    (clear_n),
    .ld_note    (ld_note),
    .ld_play    (ld_play),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .note_count (note_count),
    .full       (full),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, returning at the falling edge where outputs are stable.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Hold the selected buttons low for one clock; returns in the cycle the press is seen.
  task automatic press(input logic [3:0] m);
    {clear_n, stop_n, playback_n, load_n} = ~m;
    cyc(1);
    {clear_n, stop_n, playback_n, load_n} = 4'b1111;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic record_notes(input int n);
    for (int i = 0; i < n; i++) begin
      press(B_LOAD);
      cyc(2);
    end
  endtask

  initial begin
    int pulses;
    int pulse_at;
    logic [31:0] pulse_addr;

    reset = 1'b0;
    {clear_n, stop_n, playback_n, load_n} = 4'b1111;
    #12;
    check("rst_ld_note", ld_note, 0);
    check("rst_ld_play", ld_play, 0);
    check("rst_busy", busy, 0);
    check("rst_count", note_count, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_full", full, 0);
    @(negedge clk);
    reset = 1'b1;

    // Held load button yields a single strobe two cycles after the press.
    pulses = 0; pulse_at = -1; pulse_addr = 32'hffff_ffff;
    load_n = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (ld_note) begin
        pulses++;
        pulse_at = i;
        pulse_addr = 32'(wr_addr);
      end
    end
    load_n = 1'b1;
    check("hold_pulses", pulses, 1);
    check("hold_latency", pulse_at, 2);
    check("hold_wr_addr", pulse_addr, 0);
    check("hold_count", note_count, 1);

    // Fill to DEPTH, then one more press is ignored.
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      check("fill_full_before", full, 0);
      press(B_LOAD);
      cyc(1);
      check("fill_strobe", ld_note, 1);
      check("fill_wr_addr", wr_addr, k);
      cyc(1);
      check("fill_count", note_count, k + 1);
    end
    check("fill_full", full, 1);
    press(B_LOAD);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (ld_note) pulses++;
    end
    check("full_no_strobe", pulses, 0);
    check("full_count_held", note_count, 4);

    // Single-pass playback of three notes, four cycles each.
    do_reset();
    record_notes(3);
    check("play3_count", note_count, 3);
    press(B_PLAY);
    for (int i = 1; i <= 14; i++) begin
      cyc(1);
      check("play3_ld_play", ld_play, (i <= 12) ? 1 : 0);
      check("play3_rd_addr", rd_addr, (i <= 12) ? (i - 1) / 4 : 0);
    end
    check("play3_busy_end", busy, 0);

    // Playback with an empty store is ignored.
    do_reset();
    press(B_PLAY);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("empty_ld_play", ld_play, 0);
      check("empty_busy", busy, 0);
    end

    // Stop press landing on the tick at rd_addr=1 wins over the advance.
    do_reset();
    record_notes(3);
    press(B_PLAY);
    cyc(7);
    check("stop_pre_rd", rd_addr, 1);
    press(B_STOP);
    check("stop_at_tick_play", ld_play, 1);
    check("stop_at_tick_rd", rd_addr, 1);
    cyc(1);
    check("stop_busy", busy, 0);
    check("stop_ld_play", ld_play, 0);
    check("stop_rd_addr", rd_addr, 0);

`ifdef NOTE_SEQ_LOOP_EN
    do_reset();
    record_notes(2);
    press(B_PLAY);
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      check("loop_rd_addr", rd_addr, ((i - 1) / 4) % 2);
      check("loop_ld_play", ld_play, 1);
    end
    press(B_STOP);
    cyc(1);
    check("loop_stop_busy", busy, 0);
`endif

    // Clear beats load when both arrive together.
    do_reset();
    record_notes(2);
    check("clr_pre_count", note_count, 2);
    press(B_CLEAR | B_LOAD);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (ld_note) pulses++;
    end
    check("clr_no_strobe", pulses, 0);
    check("clr_count", note_count, 0);

    // Asynchronous reset mid-playback clears outputs without a clock edge.
    do_reset();
    record_notes(2);
    press(B_PLAY);
    cyc(5);
    check("arst_pre_busy", busy, 1);
    check("arst_pre_rd", rd_addr, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ld_play", ld_play, 0);
    check("arst_rd_addr", rd_addr, 0);
    check("arst_count", note_count, 0);
    check("arst_ld_note", ld_note, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_seq_ctrl.md
Name: note_seq_ctrl

Overview:
- Parametrised record/playback sequencer controller. Successor to the fixed 16-note controller.
- Records one note per load press into a note store of DEPTH entries.
- Plays stored notes back at a fixed tempo derived from TICK_CYCLES. Supports stop, clear and a full flag.
- Sits between the debounced push-button inputs and the note RAM / tone generator datapath.

Parameters:
- DEPTH, 16: maximum number of notes stored; must be at least 2.
- TICK_CYCLES, 25000000: clk cycles per playback note (0.5 s at 50 MHz); must be at least 2.
- AW, $clog2(DEPTH): width of the note address.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- load_n  in  1  record button, active-low level.
- playback_n  in  1  play button, active-low level.
- stop_n  in  1  stop button, active-low level.
- clear_n  in  1  erase-recording button, active-low level.
- ld_note  out  1  one-cycle write strobe to the note RAM.
- ld_play  out  1  high while the playback output is valid.
- wr_addr  out  AW  RAM write address; equals note_count.
- rd_addr  out  AW  RAM read address during playback.
- note_count  out  AW+1  number of notes recorded, 0..DEPTH.
- full  out  1  high when note_count == DEPTH.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE; all outputs 0; note_count=0; rd_addr=0; tick counter=0.
  - Button edge history registers are set to 1 (released).
- Edge detection: each button is registered once. A press is a 1->0 transition seen between consecutive cycles. A held button generates exactly one press.
- States: IDLE, RECORD, PLAY.
- IDLE priority when several presses arrive in the same cycle: clear > load > playback. stop is ignored in IDLE.
  - clear press: note_count <= 0 next cycle; stay in IDLE.
  - load press with full=0: go to RECORD.
  - load press with full=1: ignored; no strobe.
  - playback press with note_count>0: go to PLAY; rd_addr <= 0; tick counter <= 0.
  - playback press with note_count==0: ignored.
- RECORD lasts exactly 1 cycle:
  - ld_note=1 and wr_addr=note_count.
  - Next cycle: note_count increments and state returns to IDLE.
  - Latency from press to strobe is 2 cycles: edge register, then state.
- PLAY:
  - ld_play=1; tick counter counts 0..TICK_CYCLES-1 and then wraps.
  - tick is high when counter == TICK_CYCLES-1.
  - On tick with rd_addr < note_count-1: rd_addr increments.
  - On tick with rd_addr == note_count-1: state goes to IDLE; rd_addr <= 0; ld_play drops the next cycle.
  - Each note is therefore held for exactly TICK_CYCLES cycles.
  - stop press: IDLE next cycle, overriding a simultaneous tick; rd_addr <= 0.
  - load, playback and clear presses are ignored.
- Tick counter runs only in PLAY and is held at 0 elsewhere. The first note gets a full period. This replaces the free-running divider of the previous generation.
- full is combinational on note_count. wr_addr is note_count[AW-1:0] and is only meaningful when full=0.
- Reset mid-PLAY or mid-RECORD aborts immediately. The recording is lost (note_count=0).

Optional Feature:
- Macro: NOTE_SEQ_LOOP_EN.
- Defined: in PLAY, a tick on the last note wraps rd_addr to 0 and stays in PLAY. Playback loops until a stop press. A playback press during PLAY restarts from address 0 with the tick counter cleared.
- Undefined: single-pass playback as described in Behaviour; playback presses in PLAY are ignored.

Decomposition:
- Shared package note_seq_pkg holds:
  - state typedef (IDLE=2'd0, RECORD=2'd1, PLAY=2'd2);
  - default constants NOTE_DEPTH_DEF=16 and NOTE_TICK_DEF=25000000.
- One natural sub-module: note_tick_gen.
  - Parametrised by TICK_CYCLES; inputs clk, reset, enable; output tick.
  - Holds its count at 0 while enable=0.

Test Plan (DEPTH=4, TICK_CYCLES=4 unless stated):
- Reset, then hold load_n low for 10 cycles -> exactly one ld_note pulse with wr_addr=0, 2 cycles after the press; note_count=1.
- 4 load presses, then a 5th -> 4 strobes at wr_addr 0,1,2,3; full=1 after the 4th; 5th press gives no strobe; note_count stays 4.
- 3 notes recorded, then a playback press -> ld_play high 12 cycles; rd_addr 0,1,2 for 4 cycles each; then IDLE, ld_play=0, busy=0.
- Playback press with note_count=0 -> stays IDLE; ld_play never asserts.
- During PLAY at rd_addr=1, stop press coincident with tick -> IDLE next cycle; rd_addr=0; no advance to 2. With NOTE_SEQ_LOOP_EN and 2 notes, no stop -> rd_addr sequence 0,1,0,1 and still in PLAY after 16 cycles.
- clear_n and load_n pressed in the same cycle in IDLE with note_count=2 -> note_count=0, no ld_note. Separately, async reset asserted mid-PLAY -> all outputs 0 with no clock edge.
